pll_meas_array: RTL and testbench

PLL_MEAS_ARRAY -- requirements
Module: pll_meas_array

---
 rtl/pll_meas_array.sv | 228 ++++++++++++++++++++++
 tb/tb_pll_meas_array.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pll_meas_array.sv
// pll_meas_array: multi-channel event counter for PLL frequency checks.
// Each channel counts ch_tick strobes over a programmable window of
// avalon_clock cycles. The count is latched into RESULT[i] at the window end.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no window open; counters and ref hold; waiting for go
// RUN   | window open; ref counts elapsed cycles, live[i] counts ticks
module pll_meas_array #(
    parameter logic [31:0] ID     = 32'd1,
    parameter int          NUM_CH = 4,
    parameter int          CNT_W  = 32
) (
    input  logic              avalon_clock,
    input  logic              reset,
    input  logic [3:0]        address,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic              read,
    output logic [31:0]       readdata,
    input  logic [NUM_CH-1:0] ch_tick,
    input  logic [NUM_CH-1:0] locked,
    output logic              irq
);

    localparam logic [3:0] ADDR_CTRL   = 4'd0;
    localparam logic [3:0] ADDR_WINDOW = 4'd1;
    localparam logic [3:0] ADDR_STATUS = 4'd2;
    localparam logic [3:0] ADDR_REF    = 4'd3;
    localparam logic [3:0] ADDR_ID     = 4'd4;
    localparam logic [3:0] ADDR_LOCKED = 4'd5;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [31:0]      WIN_LIMIT = 32'((64'd1 << CNT_W) - 64'd1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0]  window_q;
    logic [CNT_W-1:0]  window_shadow_q;
    logic [CNT_W-1:0]  ref_q;
    logic [CNT_W-1:0]  live_q    [NUM_CH];
    logic [CNT_W-1:0]  live_next [NUM_CH];
    logic [CNT_W-1:0]  result_q  [NUM_CH];
    logic              cont_q;
    logic              cont_run_q;
    logic              irq_en_q;
    logic              done_q;
    logic [NUM_CH-1:0] ovf_q;
    logic [NUM_CH-1:0] ovf_hit;
    logic [31:0]       rd_data;

    logic wr_ctrl;
    logic wr_window;
    logic wr_status;
    logic go_req;
    logic abort_req;
    logic start;
    logic run_step;
    logic window_end;
    logic busy;

    assign wr_ctrl   = write && (address == ADDR_CTRL);
    assign wr_window = write && (address == ADDR_WINDOW);
    assign wr_status = write && (address == ADDR_STATUS);
    // Abort wins over go when both bits are set in the same write.
    assign go_req    = wr_ctrl && writedata[0] && !writedata[3];
    assign abort_req = wr_ctrl && writedata[3];

    assign busy       = (state_q == RUN);
    assign run_step   = busy && !abort_req;
    assign window_end = busy && (ref_q == window_shadow_q);

    assign irq = done_q & irq_en_q;

    // State register.
    always_ff @(posedge avalon_clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start pulses on the IDLE->RUN transition.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (go_req) begin
                    state_d = RUN;
                    start   = 1'b1;
                end
            end
            RUN: begin
                if (abort_req) begin
                    state_d = IDLE;
                end else if (window_end && !cont_run_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating next value of each live counter, including this cycle's tick.
    // ovf flags a counter that has reached its ceiling, because from there on
    // the count no longer reflects the true number of ticks.
    always_comb begin
        ovf_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            live_next[i] = live_q[i];
            if (ch_tick[i] && (live_q[i] != CNT_MAX)) begin
                live_next[i] = live_q[i] + CNT_ONE;
            end
            ovf_hit[i] = run_step && ch_tick[i] && (live_next[i] == CNT_MAX);
        end
    end

    // Window datapath: ref, live counters, result latch and run-time shadows.
    always_ff @(posedge avalon_clock or posedge reset) begin
        if (reset) begin
            ref_q           <= '0;
            window_shadow_q <= '0;
            cont_run_q      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                live_q[i]   <= '0;
                result_q[i] <= '0;
            end
        end else if (start) begin
            ref_q           <= CNT_ONE;
            window_shadow_q <= (window_q == '0) ? CNT_ONE : window_q;
            cont_run_q      <= writedata[1];
            for (int i = 0; i < NUM_CH; i++) begin
                live_q[i] <= '0;
            end
        end else if (run_step) begin
            if (window_end) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    result_q[i] <= live_next[i];
                    live_q[i]   <= cont_run_q ? '0 : live_next[i];
                end
                if (cont_run_q) begin
                    ref_q <= CNT_ONE;
                end
            end else begin
                ref_q <= ref_q + CNT_ONE;
                for (int i = 0; i < NUM_CH; i++) begin
                    live_q[i] <= live_next[i];
                end
            end
        end
    end

    // Control and window configuration registers. Writes too large for the
    // window width clamp to the longest window rather than wrapping.
    always_ff @(posedge avalon_clock or posedge reset) begin
        if (reset) begin
            window_q <= '0;
            cont_q   <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            if (wr_window) begin
                window_q <= (writedata > WIN_LIMIT) ? CNT_MAX : writedata[CNT_W-1:0];
            end
            if (wr_ctrl) begin
                cont_q   <= writedata[1];
                irq_en_q <= writedata[2];
            end
        end
    end

    // Sticky status flags; a window-end set beats a same-cycle STATUS clear.
    always_ff @(posedge avalon_clock or posedge reset) begin
        if (reset) begin
            done_q <= 1'b0;
            ovf_q  <= '0;
        end else begin
            if (run_step && window_end) begin
                done_q <= 1'b1;
            end else if (wr_status) begin
                done_q <= 1'b0;
            end
            ovf_q <= (wr_status ? '0 : ovf_q) | ovf_hit;
        end
    end

    // Read mux over the register map.
    always_comb begin
        rd_data = '0;
        case (address)
            ADDR_CTRL:   rd_data = {29'b0, irq_en_q, cont_q, busy};
            ADDR_WINDOW: rd_data = 32'(window_q);
            ADDR_STATUS: begin
                rd_data[9]        = busy;
                rd_data[NUM_CH:1] = ovf_q;
                rd_data[0]        = done_q;
            end
            ADDR_REF:    rd_data = 32'(ref_q);
            ADDR_ID:     rd_data = ID;
            ADDR_LOCKED: rd_data = 32'(locked);
            default: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (address == 4'(8 + i)) begin
                        rd_data = 32'(result_q[i]);
                    end
                end
            end
        endcase
    end

    // Registered read data; holds its value between reads.
    always_ff @(posedge avalon_clock or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else if (read) begin
            readdata <= rd_data;
        end
    end

endmodule

// File: tb/tb_pll_meas_array.sv
// tb_pll_meas_array: directed register-level checks of pll_meas_array,
// instantiated with an 8-bit counter width so saturation is reachable.
module tb_pll_meas_array;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    logic              avalon_clock = 1'b0;
    logic              reset        = 1'b1;
    logic [3:0]        address      = '0;
    logic              write        = 1'b0;
    logic [31:0]       writedata    = '0;
    logic              read         = 1'b0;
    logic [31:0]       readdata;
    logic [NUM_CH-1:0] ch_tick;
    logic [NUM_CH-1:0] locked       = '0;
    logic              irq;

    logic [NUM_CH-1:0] tick_base = '0;
    logic              tog_en    = 1'b0;
    logic              tog       = 1'b0;

    int total = 0;
    int bad   = 0;
    logic [31:0] rd;

    assign ch_tick = tick_base | ((tog_en && tog) ? 4'b0010 : 4'b0000);

    pll_meas_array #(.ID(32'd1), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .avalon_clock (avalon_clock),
        .reset        (reset),
        .address      (address),
        .write        (write),
        .writedata    (writedata),
        .read         (read),
        .readdata     (readdata),
        .ch_tick      (ch_tick),
        .locked       (locked),
        .irq          (irq)
    );

    always #5 avalon_clock = ~avalon_clock;

    // Channel 1 strobes every other cycle when enabled.
    always @(negedge avalon_clock) begin
        if (tog_en) tog = ~tog;
        else        tog = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // All bus tasks start at a negedge and consume exactly one clock.
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge avalon_clock);
        write     = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        address = a;
        read    = 1'b1;
        @(negedge avalon_clock);
        read    = 1'b0;
        d       = readdata;
    endtask

    initial begin
        repeat (3) @(negedge avalon_clock);
        reset = 1'b0;

        // Reset state
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        bus_read(4'd0, rd); chk("rst_ctrl", rd, 32'h0);
        bus_read(4'd2, rd); chk("rst_status", rd, 32'h0);
        bus_read(4'd4, rd); chk("rst_id", rd, 32'h1);
        locked = 4'b1010;
        bus_read(4'd5, rd); chk("locked", rd, 32'hA);
        locked = 4'b0000;

        // Single-shot window of 10: ch0 constant, ch1 every other cycle
        tick_base = 4'b0001;
        tog_en    = 1'b1;
        bus_write(4'd1, 32'd10);
        bus_read(4'd1, rd); chk("window_rd", rd, 32'd10);
        bus_write(4'd0, 32'h1);
        bus_read(4'd0, rd); chk("busy_run", rd, 32'h1);
        repeat (9) @(negedge avalon_clock);
        tick_base = '0;
        tog_en    = 1'b0;
        bus_read(4'd8, rd);  chk("w10_res0", rd, 32'd10);
        bus_read(4'd9, rd);  chk("w10_res1", rd, 32'd5);
        bus_read(4'd2, rd);  chk("w10_status", rd, 32'h1);
        bus_read(4'd3, rd);  chk("w10_ref", rd, 32'd10);
        chk("w10_irq_off", {31'b0, irq}, 32'h0);

        // WINDOW=0 behaves as a one-cycle window; irq enabled
        bus_write(4'd2, 32'h0);
        bus_write(4'd1, 32'd0);
        tick_base = 4'b1111;
        bus_write(4'd0, 32'h5);
        @(negedge avalon_clock);
        chk("w1_irq", {31'b0, irq}, 32'h1);
        tick_base = '0;
        bus_read(4'd8, rd);  chk("w1_res0", rd, 32'd1);
        bus_read(4'd3, rd);  chk("w1_ref", rd, 32'd1);
        bus_read(4'd0, rd);  chk("w1_ctrl", rd, 32'h4);
        bus_write(4'd2, 32'h0);
        chk("w1_irq_clr", {31'b0, irq}, 32'h0);

        // Oversized window clamps to 255; ch2 saturates and flags ovf
        bus_write(4'd1, 32'd300);
        bus_read(4'd1, rd); chk("win_clamp", rd, 32'd255);
        tick_base = 4'b0100;
        bus_write(4'd0, 32'h1);
        repeat (260) @(negedge avalon_clock);
        tick_base = '0;
        bus_read(4'd10, rd); chk("sat_res2", rd, 32'd255);
        bus_read(4'd8, rd);  chk("sat_res0", rd, 32'd0);
        bus_read(4'd2, rd);  chk("sat_status", rd, 32'h9);
        bus_write(4'd2, 32'h0);
        bus_read(4'd2, rd);  chk("sat_clr", rd, 32'h0);

        // Continuous windows of 4 back to back, then abort
        bus_write(4'd1, 32'd4);
        tick_base = 4'b1111;
        bus_write(4'd0, 32'h3);
        repeat (8) @(negedge avalon_clock);
        bus_read(4'd3, rd);  chk("cont_ref1", rd, 32'd1);
        bus_read(4'd11, rd); chk("cont_res3", rd, 32'd4);
        bus_read(4'd0, rd);  chk("cont_ctrl", rd, 32'h3);
        bus_read(4'd3, rd);  chk("cont_ref4", rd, 32'd4);
        tick_base = '0;
        bus_write(4'd0, 32'h9);
        bus_read(4'd0, rd);  chk("abort_ctrl", rd, 32'h0);
        bus_read(4'd11, rd); chk("abort_res3", rd, 32'd4);
        bus_read(4'd3, rd);  chk("abort_ref", rd, 32'd1);
        bus_read(4'd8, rd);  chk("abort_res0", rd, 32'd4);

        // Reset asserted mid-run abandons the window and clears everything
        bus_write(4'd2, 32'h0);
        bus_write(4'd1, 32'd50);
        tick_base = 4'b1111;
        bus_write(4'd0, 32'h5);
        repeat (5) @(negedge avalon_clock);
        #2 reset = 1'b1;
        #1 chk("mid_rst_irq", {31'b0, irq}, 32'h0);
        @(negedge avalon_clock);
        reset = 1'b0;
        repeat (60) @(negedge avalon_clock);
        tick_base = '0;
        for (int a = 0; a < 16; a++) begin
            bus_read(4'(a), rd);
            chk($sformatf("post_rst_a%0d", a), rd, (a == 4) ? 32'h1 : 32'h0);
        end
        chk("post_rst_irq", {31'b0, irq}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
